matrix_b_loader: RTL and testbench

Parametrised, double-buffered operand loader for the B matrix of the matrix engine. It accepts a stream of elements one per cycle, packs `ELEMS` of them into a bank, and presents each completed bank as one wide word to the compute datapath. Up to `NUM_BANKS` complete matrices are queued in FIFO order, so loading of the next operand overlaps consumption of the current one. It adds write back-pressure, abort/clear modes and error reporting.

---
 rtl/matrix_b_loader_pkg.sv | 14 +
 rtl/matrix_b_loader_if.sv | 28 ++
 rtl/matrix_b_loader_bank.sv | 30 +++
 rtl/matrix_b_loader.sv | 103 ++++++++++
 tb/tb_matrix_b_loader.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/matrix_b_loader_pkg.sv
// Shared opcode encodings and pointer helper for the B-operand loader.
package matrix_pkg;

   localparam logic [1:0] B_OP_IDLE  = 2'b00;
   localparam logic [1:0] B_OP_WRITE = 2'b01;
   localparam logic [1:0] B_OP_ABORT = 2'b10;
   localparam logic [1:0] B_OP_CLEAR = 2'b11;

   // Bank pointers wrap at an arbitrary depth, not only at powers of two.
   function automatic logic [31:0] ptr_wrap(input logic [31:0] p, input int unsigned n);
      return (p == n - 1) ? 32'd0 : p + 32'd1;
   endfunction

endpackage

// File: rtl/matrix_b_loader_if.sv
// Write/consume bus between a B-operand producer and the loader.
interface matrix_b_loader_if #(
   parameter int DATA_W    = 32,
   parameter int ELEMS     = 4,
   parameter int NUM_BANKS = 2
);
   localparam int CNT_W = $clog2(NUM_BANKS + 1);

   logic [1:0]              B_opcode;
   logic [DATA_W-1:0]       Data_to_B;
   logic                    B_ready;
   logic                    Busy_B;
   logic [DATA_W*ELEMS-1:0] Data_out;
   logic                    Out_valid;
   logic                    Consume;
   logic [CNT_W-1:0]        Full_count;
   logic                    Err_B;

   modport master (
      output B_opcode, Data_to_B, Consume,
      input  B_ready, Busy_B, Data_out, Out_valid, Full_count, Err_B
   );

   modport slave (
      input  B_opcode, Data_to_B, Consume,
      output B_ready, Busy_B, Data_out, Out_valid, Full_count, Err_B
   );
endinterface

// File: rtl/matrix_b_loader_bank.sv
// One matrix worth of element storage with per-element write enables.
module matrix_bank #(
   parameter int DATA_W = 32,
   parameter int ELEMS  = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    clr,
   input  logic [ELEMS-1:0]        we,
   input  logic [DATA_W-1:0]       wdata,
   output logic [DATA_W*ELEMS-1:0] rdata
);
   logic [DATA_W-1:0] mem [ELEMS];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int e = 0; e < ELEMS; e++) mem[e] <= '0;
      end else if (clr) begin
         for (int e = 0; e < ELEMS; e++) mem[e] <= '0;
      end else begin
         for (int e = 0; e < ELEMS; e++) begin
            if (we[e]) mem[e] <= wdata;
         end
      end
   end

   for (genvar e = 0; e < ELEMS; e++) begin : g_rd
      assign rdata[e*DATA_W +: DATA_W] = mem[e];
   end
endmodule

// File: rtl/matrix_b_loader.sv
// Queued B-operand loader: packs streamed elements into banks and presents
// completed banks in FIFO order to the compute datapath.
module matrix_b_loader
   import matrix_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ELEMS     = 4,
   parameter int NUM_BANKS = 2
) (
   input logic               clk,
   input logic               reset_n,
   matrix_b_loader_if.slave  bus
);
   localparam int PTR_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam int IDX_W = $clog2(ELEMS);
   localparam int CNT_W = $clog2(NUM_BANKS + 1);
   localparam int WORD_W = DATA_W * ELEMS;

   logic [PTR_W-1:0] wp, rp;
   logic [IDX_W-1:0] idx;
   logic [CNT_W-1:0] count;
   logic             err;

   logic ready, op_write, op_abort, op_clear;
   logic wr_acc, wr_last, do_cons, cons_err;

   assign ready    = (count < CNT_W'(NUM_BANKS));
   assign op_write = (bus.B_opcode == B_OP_WRITE);
   assign op_abort = (bus.B_opcode == B_OP_ABORT);
   assign op_clear = (bus.B_opcode == B_OP_CLEAR);
   assign wr_acc   = op_write && ready;
   assign wr_last  = wr_acc && (idx == IDX_W'(ELEMS - 1));
   assign do_cons  = bus.Consume && (count != '0) && !op_clear;
   assign cons_err = bus.Consume && (count == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wp    <= '0;
         rp    <= '0;
         idx   <= '0;
         count <= '0;
         err   <= 1'b0;
      end else if (op_clear) begin
         wp    <= '0;
         rp    <= '0;
         idx   <= '0;
         count <= '0;
         err   <= 1'b0;
      end else begin
         if (wr_last) begin
            idx <= '0;
            wp  <= PTR_W'(ptr_wrap(32'(wp), NUM_BANKS));
         end else if (wr_acc) begin
            idx <= idx + IDX_W'(1);
         end else if (op_abort) begin
            idx <= '0;
         end
         if (do_cons) rp <= PTR_W'(ptr_wrap(32'(rp), NUM_BANKS));
         // Completion and release in one cycle leave the occupancy unchanged.
         if (wr_last && !do_cons) count <= count + CNT_W'(1);
         else if (!wr_last && do_cons) count <= count - CNT_W'(1);
         if ((op_write && !ready) || cons_err) err <= 1'b1;
      end
   end

   logic [WORD_W-1:0] bank_rd [NUM_BANKS];

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [ELEMS-1:0] we;

      always_comb begin
         we = '0;
         for (int e = 0; e < ELEMS; e++) begin
            if (wr_acc && (wp == PTR_W'(b)) && (idx == IDX_W'(e))) we[e] = 1'b1;
         end
      end

      matrix_bank #(.DATA_W(DATA_W), .ELEMS(ELEMS)) u_bank (
         .clk     (clk),
         .reset_n (reset_n),
         .clr     (op_clear),
         .we      (we),
         .wdata   (bus.Data_to_B),
         .rdata   (bank_rd[b])
      );
   end

   logic [WORD_W-1:0] rd_sel;

   always_comb begin
      rd_sel = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (rp == PTR_W'(b)) rd_sel = bank_rd[b];
      end
   end

   assign bus.B_ready    = ready;
   assign bus.Busy_B     = (idx != '0);
   assign bus.Out_valid  = (count != '0);
   assign bus.Data_out   = (count != '0) ? rd_sel : '0;
   assign bus.Full_count = count;
   assign bus.Err_B      = err;
endmodule

// File: tb/tb_matrix_b_loader.sv
// Bench for matrix_b_loader: directed scenarios plus random traffic against a
// queue-based model, on a default and a 16/9/3 configuration.
module tb_matrix_b_loader;
   import matrix_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   matrix_b_loader_if #(.DATA_W(32), .ELEMS(4), .NUM_BANKS(2)) ifa ();
   matrix_b_loader_if #(.DATA_W(16), .ELEMS(9), .NUM_BANKS(3)) ifb ();

   matrix_b_loader #(.DATA_W(32), .ELEMS(4), .NUM_BANKS(2)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .bus(ifa));
   matrix_b_loader #(.DATA_W(16), .ELEMS(9), .NUM_BANKS(3)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .bus(ifb));

   int n_cmp = 0;
   int n_bad = 0;

   int m_dw, m_el, m_nb;
   logic [31:0]  m_mask;
   logic [255:0] mq[$];
   logic [31:0]  part[$];
   logic         m_err;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_cfg(input int sel);
      if (sel == 0) begin m_dw = 32; m_el = 4; m_nb = 2; end
      else          begin m_dw = 16; m_el = 9; m_nb = 3; end
      m_mask = (m_dw == 32) ? 32'hffff_ffff : ((32'd1 << m_dw) - 32'd1);
   endtask

   task automatic model_reset();
      mq.delete();
      part.delete();
      m_err = 1'b0;
   endtask

   task automatic model_step(input logic [1:0] op, input logic [31:0] d, input logic cons);
      int sz;
      logic done;
      logic [255:0] w;
      sz = mq.size();
      done = 1'b0;
      w = '0;
      if (op == B_OP_CLEAR) begin
         model_reset();
         return;
      end
      if (op == B_OP_WRITE) begin
         if (sz < m_nb) begin
            part.push_back(d & m_mask);
            if (part.size() == m_el) begin
               for (int i = 0; i < m_el; i++) w = w | (256'(part[i]) << (i * m_dw));
               part.delete();
               done = 1'b1;
            end
         end else begin
            m_err = 1'b1;
         end
      end
      if (op == B_OP_ABORT) part.delete();
      if (cons) begin
         if (sz > 0) void'(mq.pop_front());
         else m_err = 1'b1;
      end
      if (done) mq.push_back(w);
   endtask

   logic         o_rdy, o_busy, o_vld, o_err;
   logic [255:0] o_data;
   logic [7:0]   o_fc;

   task automatic sample(input int sel);
      if (sel == 0) begin
         o_rdy = ifa.B_ready; o_busy = ifa.Busy_B; o_vld = ifa.Out_valid;
         o_err = ifa.Err_B; o_data = 256'(ifa.Data_out); o_fc = 8'(ifa.Full_count);
      end else begin
         o_rdy = ifb.B_ready; o_busy = ifb.Busy_B; o_vld = ifb.Out_valid;
         o_err = ifb.Err_B; o_data = 256'(ifb.Data_out); o_fc = 8'(ifb.Full_count);
      end
   endtask

   task automatic compare_all(input int sel);
      sample(sel);
      chk("B_ready",    256'(o_rdy),  256'(mq.size() < m_nb));
      chk("Busy_B",     256'(o_busy), 256'(part.size() != 0));
      chk("Out_valid",  256'(o_vld),  256'(mq.size() > 0));
      chk("Full_count", 256'(o_fc),   256'(mq.size()));
      chk("Err_B",      256'(o_err),  256'(m_err));
      chk("Data_out",   o_data,       (mq.size() > 0) ? mq[0] : 256'd0);
   endtask

   task automatic drive(input int sel, input logic [1:0] op, input logic [31:0] d, input logic cons);
      ifa.B_opcode = B_OP_IDLE; ifa.Data_to_B = '0; ifa.Consume = 1'b0;
      ifb.B_opcode = B_OP_IDLE; ifb.Data_to_B = '0; ifb.Consume = 1'b0;
      if (sel == 0) begin
         ifa.B_opcode = op; ifa.Data_to_B = d; ifa.Consume = cons;
      end else begin
         ifb.B_opcode = op; ifb.Data_to_B = d[15:0]; ifb.Consume = cons;
      end
   endtask

   task automatic cyc(input int sel, input logic [1:0] op, input logic [31:0] d, input logic cons);
      @(negedge clk);
      drive(sel, op, d, cons);
      @(posedge clk);
      #1;
      model_step(op, d, cons);
      compare_all(sel);
   endtask

   // Reset lands between edges; outputs are checked before any clock edge follows.
   task automatic async_reset(input int sel);
      @(negedge clk);
      drive(sel, B_OP_IDLE, 32'd0, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      compare_all(sel);
      #1 reset_n = 1'b1;
   endtask

   task automatic random_run(input int sel, input int ncyc);
      logic [1:0] op;
      int r;
      for (int i = 0; i < ncyc; i++) begin
         r = $urandom_range(99);
         if (r < 62)      op = B_OP_WRITE;
         else if (r < 88) op = B_OP_IDLE;
         else if (r < 97) op = B_OP_ABORT;
         else             op = B_OP_CLEAR;
         cyc(sel, op, $urandom, ($urandom_range(99) < 30) ? 1'b1 : 1'b0);
      end
   endtask

   initial begin
      drive(0, B_OP_IDLE, 32'd0, 1'b0);
      model_cfg(0);
      model_reset();
      #3;
      compare_all(0);
      compare_all(1);
      #4 reset_n = 1'b1;

      // single fill
      cyc(0, B_OP_WRITE, 32'h11, 1'b0);
      chk("fill_busy1", 256'(ifa.Busy_B), 256'd1);
      cyc(0, B_OP_WRITE, 32'h22, 1'b0);
      cyc(0, B_OP_WRITE, 32'h33, 1'b0);
      chk("fill_valid_early", 256'(ifa.Out_valid), 256'd0);
      cyc(0, B_OP_WRITE, 32'h44, 1'b0);
      chk("fill_busy4", 256'(ifa.Busy_B), 256'd0);
      chk("fill_valid", 256'(ifa.Out_valid), 256'd1);
      chk("fill_data", 256'(ifa.Data_out), 256'h00000044_00000033_00000022_00000011);

      // back-pressure
      for (int i = 0; i < 4; i++) cyc(0, B_OP_WRITE, 32'h100 + i, 1'b0);
      chk("bp_ready", 256'(ifa.B_ready), 256'd0);
      chk("bp_count", 256'(ifa.Full_count), 256'd2);
      cyc(0, B_OP_WRITE, 32'hdead, 1'b0);
      chk("bp_err", 256'(ifa.Err_B), 256'd1);
      chk("bp_keep", 256'(ifa.Data_out), 256'h00000044_00000033_00000022_00000011);
      cyc(0, B_OP_IDLE, 32'd0, 1'b1);
      chk("bp_ready_back", 256'(ifa.B_ready), 256'd1);
      chk("bp_second", 256'(ifa.Data_out), 256'h00000103_00000102_00000101_00000100);

      // completion coinciding with consume
      for (int i = 0; i < 3; i++) cyc(0, B_OP_WRITE, 32'h200 + i, 1'b0);
      cyc(0, B_OP_WRITE, 32'h203, 1'b1);
      chk("sim_count", 256'(ifa.Full_count), 256'd1);
      chk("sim_data", 256'(ifa.Data_out), 256'h00000203_00000202_00000201_00000200);

      // abort
      cyc(0, B_OP_IDLE, 32'd0, 1'b1);
      cyc(0, B_OP_WRITE, 32'h55, 1'b0);
      cyc(0, B_OP_WRITE, 32'h66, 1'b0);
      cyc(0, B_OP_ABORT, 32'd0, 1'b0);
      for (int i = 0; i < 4; i++) cyc(0, B_OP_WRITE, 32'hA + i, 1'b0);
      chk("abort_data", 256'(ifa.Data_out), 256'h0000000D_0000000C_0000000B_0000000A);

      // clear and errors
      cyc(0, B_OP_IDLE, 32'd0, 1'b1);
      cyc(0, B_OP_IDLE, 32'd0, 1'b1);
      for (int i = 0; i < 4; i++) cyc(0, B_OP_WRITE, 32'h300 + i, 1'b0);
      cyc(0, B_OP_CLEAR, 32'd0, 1'b1);
      chk("clr_count", 256'(ifa.Full_count), 256'd0);

      // reset mid-fill with a bank queued
      for (int i = 0; i < 6; i++) cyc(0, B_OP_WRITE, $urandom, 1'b0);
      async_reset(0);
      for (int i = 0; i < 4; i++) cyc(0, B_OP_WRITE, $urandom, 1'b0);
      random_run(0, 600);

      // 16-bit, 9-element, 3-bank configuration
      model_cfg(1);
      async_reset(1);
      for (int i = 0; i < 9 * 3 + 2; i++) cyc(1, B_OP_WRITE, $urandom, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1, B_OP_IDLE, 32'd0, 1'b1);
      for (int i = 0; i < 9 * 4; i++) cyc(1, B_OP_WRITE, $urandom, (i % 9) == 8);
      for (int i = 0; i < 5; i++) cyc(1, B_OP_WRITE, $urandom, 1'b0);
      async_reset(1);
      random_run(1, 900);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
